// File: rtl/sim_input_ctrl.sv
// sim_input_ctrl
// Upstream control stage for the three-body VGA simulator. Synchronises and
// debounces the button pins, then turns presses into frame-aligned commands:
// run/pause, single-step, restart, and a velocity kick of one body. Kicks are
// delivered over a valid/ready handshake.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   btn_in[7:0]  raw pins: [0] pause, [1] step, [2] restart, [3] kick,
//                [5:4] body select (11 invalid), [7:6] kick direction
//   frame_tick   one-cycle pulse at pixel (0,0)
//   sim_advance  integrate this frame (combinational with frame_tick)
//   restart      reload initial state (combinational with frame_tick)
//   running      1 = free-running, 0 = paused
//   kick_valid   kick command pending
//   kick_body    body index of pending kick
//   kick_dir     direction of pending kick
//   kick_ready   core accepts the kick this cycle
//   kick_drops   saturating count of kick presses lost while one was pending
//   btn_db       debounced levels of btn_in[3:0]
module sim_input_ctrl #(
    parameter int unsigned DB_CYCLES = 250000,
    parameter int unsigned DB_W      = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] btn_in,
    input  logic       frame_tick,
    output logic       sim_advance,
    output logic       restart,
    output logic       running,
    output logic       kick_valid,
    output logic [1:0] kick_body,
    output logic [1:0] kick_dir,
    input  logic       kick_ready,
    output logic [3:0] kick_drops,
    output logic [3:0] btn_db
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [7:0]      sync1;
    logic [7:0]      sync2;
    logic [DB_W-1:0] db_cnt [4];
    logic [3:0]      btn_db_d;
    logic [3:0]      press;
    logic            step_pending;
    logic            restart_pending;

    logic kick_xfer;
    logic kick_sel_ok;
    logic frame_restart;

    assign kick_xfer     = kick_valid & kick_ready;
    assign kick_sel_ok   = (sync2[5:4] != 2'b11);
    assign frame_restart = frame_tick & restart_pending;

    // Combinational so both pulses stay coincident with frame_tick.
    assign restart     = frame_restart;
    assign sim_advance = frame_tick & ~restart_pending & (running | step_pending);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    // Counter runs only while the synchronised level disagrees with btn_db;
    // any agreement restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_db[i] <= ~btn_db[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db_d <= '0;
            press    <= '0;
        end else begin
            btn_db_d <= btn_db;
            press    <= btn_db & ~btn_db_d;
        end
    end

    // Later assignments take priority: a press arriving with frame_tick is
    // latched for the next frame, and a restart on frame_tick always leaves
    // kick_valid low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running         <= 1'b1;
            step_pending    <= 1'b0;
            restart_pending <= 1'b0;
            kick_valid      <= 1'b0;
            kick_body       <= '0;
            kick_dir        <= '0;
            kick_drops      <= '0;
        end else begin
            if (frame_tick) begin
                step_pending <= 1'b0;
            end
            if (press[1] && !running) begin
                step_pending <= 1'b1;
            end

            if (press[0]) begin
                running <= ~running;
            end

            if (frame_restart) begin
                restart_pending <= 1'b0;
            end
            if (press[2]) begin
                restart_pending <= 1'b1;
            end

            if (kick_xfer) begin
                kick_valid <= 1'b0;
            end
            if (press[3] && kick_sel_ok) begin
                if (!kick_valid || kick_xfer) begin
                    kick_valid <= 1'b1;
                    kick_body  <= sync2[5:4];
                    kick_dir   <= sync2[7:6];
                end else if (kick_drops != 4'hF) begin
                    kick_drops <= kick_drops + 4'd1;
                end
            end
            if (frame_restart) begin
                kick_valid <= 1'b0;
            end
        end
    end

endmodule
